// File: rtl/mips_pkg.sv
// Shared constants and loader state encoding for the MIPS
// instruction-memory loader.
package mips_pkg;

    localparam logic [7:0] IMEM_HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ldr_state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words; the 4th byte
// completes the word combinationally so the caller can latch it.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_byte_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

    assign o_word_valid = i_byte_valid && (r_idx == 2'd3);
    assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed UART byte stream.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import mips_pkg::*;
#(
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] HDR_BYTE = IMEM_HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   load_count
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [16:0]       CAP      = 17'(2**ADDR_W);

    ldr_state_e        r_state;
    ldr_state_e        w_next;
    logic [7:0]        r_len_hi;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_err;
    logic              r_hold;

    logic              w_hdr;
    logic              w_restart;
    logic              w_byte_valid;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_last;
    logic [16:0]       w_len;
    logic              w_len_bad;
    logic              w_release;

    assign w_hdr        = rx_valid && (rx_data == HDR_BYTE);
    assign w_restart    = w_hdr && (r_state == ST_IDLE ||
                                    r_state == ST_DONE ||
                                    r_state == ST_ERR);
    assign w_byte_valid = rx_valid && (r_state == ST_DATA);
    assign w_len        = {1'b0, r_len_hi, rx_data};
    assign w_len_bad    = (w_len == '0) || (w_len > CAP);
    assign w_last       = w_word_valid && ((r_words + CNT_ONE) == r_len);

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_restart),
        .i_byte_valid (w_byte_valid),
        .i_byte       (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_chk;

    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_chk <= '0;
        end else if (w_byte_valid) begin
            r_chk <= r_chk ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hdr) w_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (rx_valid) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (rx_valid) w_next = w_len_bad ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_last) w_next = ST_CHK;
`else
                if (w_last) w_next = ST_DONE;
`endif
            end
            ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (rx_valid) begin
                    w_next = (rx_data == r_chk) ? ST_DONE : ST_ERR;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (w_hdr) w_next = ST_LEN_HI;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_hi <= '0;
            r_len    <= '0;
        end else if (rx_valid) begin
            if (r_state == ST_LEN_HI) r_len_hi <= rx_data;
            if (r_state == ST_LEN_LO && !w_len_bad) begin
                r_len <= w_len[ADDR_W:0];
            end
        end
    end

    // Write register is separate from assembly so back-to-back bytes never stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_words <= '0;
        end else begin
            r_we <= w_word_valid;
            if (w_word_valid) r_wdata <= w_word;
            if (w_restart) begin
                r_addr  <= '0;
                r_count <= '0;
                r_words <= '0;
            end else begin
                if (w_word_valid) r_words <= r_words + CNT_ONE;
                if (r_we) begin
                    r_count <= r_count + CNT_ONE;
                    if (r_addr != ADDR_MAX) r_addr <= r_addr + ADDR_ONE;
                end
            end
        end
    end

    // DONE is entered with the final write still pending; release a cycle later.
    assign w_release = (r_state == ST_DONE) && (w_next == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_hold <= 1'b1;
        end else begin
            r_done <= w_release;
            r_err  <= (w_next == ST_ERR);
            r_hold <= !w_release;
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_err;
    assign load_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the
// stimulus and popped by a monitor on every imem_we pulse.
module tb_imem_loader;

    localparam int AW = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   load_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    wr_t exp_q[$];
    logic [31:0] wq[$];

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .load_count (load_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_t e;
            total++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected got a=%h d=%h want none",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.a || imem_wdata !== e.d) begin
                    bad++;
                    $display("FAIL wr got a=%h d=%h want a=%h d=%h",
                             imem_addr, imem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        sync();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) sync();
    endtask

    task automatic send_body(int gap);
        logic [15:0] n;
        logic [7:0]  x;
        logic [31:0] w;
        n = 16'(wq.size());
        x = 8'h00;
        send(n[15:8], gap);
        send(n[7:0], gap);
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            exp_q.push_back({AW'(i), w});
            for (int k = 0; k < 4; k++) begin
                x = x ^ w[31-8*k -: 8];
                send(w[31-8*k -: 8], gap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(x, gap);
`endif
        wq.delete();
    endtask

    task automatic send_frame(int gap);
        send(8'hA5, gap);
        send_body(gap);
    endtask

    task automatic wait_done(int lim, output int dc);
        dc = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        chk("done_seen", 32'(dc != -1), 32'd1);
        sync();
    endtask

    initial begin
        int dc;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_cnt", 32'(load_count), 32'd0);
        sync();

        // 1: basic two-word frame with idle gaps
        wq = '{32'h24080005, 32'h01095020};
        send_frame(2);
        wait_done(40, dc);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_cnt", 32'(load_count), 32'd2);
        chk("t1_err", 32'(error), 32'd0);

        // 2: same frame, bytes back-to-back
        wq = '{32'h24080005, 32'h01095020};
        send_frame(0);
        wait_done(40, dc);
        chk("t2_done_lat", 32'(dc - last_we_cyc), 32'(LAT));
        chk("t2_cnt", 32'(load_count), 32'd2);

        // 3: zero-length frame rejected, then recovered
        send(8'hA5, 1);
        send(8'h00, 1);
        send(8'h00, 1);
        @(negedge clk);
        chk("t3_err", 32'(error), 32'd1);
        chk("t3_hold", 32'(cpu_hold), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_cnt", 32'(load_count), 32'd0);
        sync();
        send(8'hA5, 0);
        @(negedge clk);
        chk("t3_err_clr", 32'(error), 32'd0);
        chk("t3_hold_rs", 32'(cpu_hold), 32'd1);
        sync();
        wq = '{32'h01020304};
        send_body(1);
        wait_done(40, dc);
        chk("t3_err_end", 32'(error), 32'd0);

        // 4: noise bytes in DONE are ignored
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h13, 1);
        @(negedge clk);
        chk("t4_noise_done", 32'(done), 32'd1);
        sync();
        wq = '{32'hAABBCCDD};
        send_frame(1);
        wait_done(40, dc);
        chk("t4_cnt", 32'(load_count), 32'd1);

        // 5: reset after 6 data bytes of a 2-word frame
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h02, 0);
        exp_q.push_back({AW'(0), 32'h10203040});
        send(8'h10, 0);
        send(8'h20, 0);
        send(8'h30, 0);
        send(8'h40, 0);
        send(8'h50, 0);
        send(8'h60, 1);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_hold", 32'(cpu_hold), 32'd1);
        chk("t5_cnt", 32'(load_count), 32'd0);
        chk("t5_we", 32'(imem_we), 32'd0);
        sync();
        send(8'h70, 0);
        send(8'h80, 2);
        chk("t5_idle_cnt", 32'(load_count), 32'd0);
        // rst with a header strobe: header must be dropped
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        sync();
        rst      = 1'b0;
        rx_valid = 1'b0;
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 0);
        send(8'hDD, 3);
        chk("t5_rsthdr_cnt", 32'(load_count), 32'd0);
        chk("t5_rsthdr_done", 32'(done), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        exp_q.push_back({AW'(0), 32'h11224488});
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h44, 0);
        send(8'h88, 0);
        send(8'hFF, 0);
        wait_done(20, dc);
        exp_q.push_back({AW'(0), 32'h11224488});
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h44, 0);
        send(8'h88, 0);
        send(8'h00, 2);
        chk("t6_err", 32'(error), 32'd1);
        chk("t6_hold", 32'(cpu_hold), 32'd1);
        chk("t6_done", 32'(done), 32'd0);
`endif

        // 7: length boundaries
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h01, 2);
        chk("t7_over_err", 32'(error), 32'd1);
        chk("t7_over_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            wq.push_back({b, ~b, 8'h5A, b ^ 8'h3C});
        end
        send_frame(0);
        wait_done(40, dc);
        chk("t7_full_cnt", 32'(load_count), 32'd256);
        chk("t7_full_addr", 32'(imem_addr), 32'd255);
        chk("t7_full_err", 32'(error), 32'd0);

        repeat (4) sync();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
